// File: rtl/console_pkg.sv
// Shared constants, character codes and state encoding for the text console controller.
package console_pkg;

    localparam int COLS = 50;
    localparam int ROWS = 38;
    localparam int XW   = 6;
    localparam int YW   = 6;
    localparam int CW   = 7;

    localparam logic [XW-1:0] LAST_COL = XW'(COLS - 1);
    localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);

    localparam logic [CW-1:0] SPACE = 7'h20;
    localparam logic [CW-1:0] CR    = 7'h0D;
    localparam logic [CW-1:0] LF    = 7'h0A;
    localparam logic [CW-1:0] BS    = 7'h08;
    localparam logic [CW-1:0] FF    = 7'h0C;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CLEAR,
        SCROLL_RD,
        SCROLL_WR,
        SCROLL_BLANK
    } state_t;

    function automatic logic is_printable(input logic [CW-1:0] c);
        return (c >= SPACE) && (c <= 7'h7E);
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Character stream, framebuffer ports and status shared between the console controller and its environment.
interface text_console_ctrl_if;
    import console_pkg::*;

    logic [CW-1:0] char_data;
    logic          char_valid;
    logic          char_ready;
    logic          disp_busy;
    logic [XW-1:0] fb_raddr_x;
    logic [YW-1:0] fb_raddr_y;
    logic [CW-1:0] fb_rdata;
    logic          fb_we;
    logic [XW-1:0] fb_waddr_x;
    logic [YW-1:0] fb_waddr_y;
    logic [CW-1:0] fb_wdata;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic          busy;

    modport master (
        input  char_data, char_valid, disp_busy, fb_rdata,
        output char_ready, fb_raddr_x, fb_raddr_y, fb_we, fb_waddr_x, fb_waddr_y,
               fb_wdata, cursor_x, cursor_y, busy
    );

    modport slave (
        output char_data, char_valid, disp_busy, fb_rdata,
        input  char_ready, fb_raddr_x, fb_raddr_y, fb_we, fb_waddr_x, fb_waddr_y,
               fb_wdata, cursor_x, cursor_y, busy
    );

endinterface

// File: rtl/console_cell_walker.sv
// Row-major (x,y) cell counter: loads (0,start_row), steps one cell per enable, flags the last cell of end_row.
module console_cell_walker
    import console_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [YW-1:0] start_row,
    input  logic [YW-1:0] end_row,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          done
);

    assign done = (x == LAST_COL) && (y == end_row);

    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= '0;
            y <= start_row;
        end else if (step) begin
            if (x == LAST_COL) begin
                x <= '0;
                y <= (y == LAST_ROW) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Console sequencer: decodes the character stream, owns the cursor and runs clear / scroll-up
// sequences over the dual-port framebuffer, yielding the read port to the display fetch.
module text_console_ctrl
    import console_pkg::*;
(
    input  logic                clk_pixel,
    input  logic                rst,
    text_console_ctrl_if.master bus
);

    state_t        state, state_n;
    logic [XW-1:0] cur_x, cur_x_n;
    logic [YW-1:0] cur_y, cur_y_n;
    logic [CW-1:0] char_q;
    logic          accept;
    logic          line_feed;

    logic          w_load, w_step, w_done;
    logic [YW-1:0] w_start_row, w_end_row;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;

    assign accept       = (state == IDLE) && bus.char_valid;
    assign bus.cursor_x = cur_x;
    assign bus.cursor_y = cur_y;

    // The copy phase stops one row early; the bottom row is blanked separately.
    assign w_end_row = (state == SCROLL_RD || state == SCROLL_WR) ? LAST_ROW - 1'b1 : LAST_ROW;

    console_cell_walker u_walker (
        .clk       (clk_pixel),
        .rst       (rst),
        .load      (w_load),
        .step      (w_step),
        .start_row (w_start_row),
        .end_row   (w_end_row),
        .x         (w_x),
        .y         (w_y),
        .done      (w_done)
    );

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state  <= CLEAR;
            cur_x  <= '0;
            cur_y  <= '0;
            char_q <= '0;
        end else begin
            state <= state_n;
            cur_x <= cur_x_n;
            cur_y <= cur_y_n;
            if (accept) char_q <= bus.char_data;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_n        = state;
        cur_x_n        = cur_x;
        cur_y_n        = cur_y;
        line_feed      = 1'b0;
        w_load         = 1'b0;
        w_step         = 1'b0;
        w_start_row    = '0;
        bus.char_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.fb_we      = 1'b0;
        bus.fb_waddr_x = '0;
        bus.fb_waddr_y = '0;
        bus.fb_wdata   = '0;
        bus.fb_raddr_x = '0;
        bus.fb_raddr_y = '0;

        case (state)
            IDLE: begin
                bus.char_ready = 1'b1;
                if (bus.char_valid) state_n = WRITE;
            end

            WRITE: begin
                state_n = IDLE;
                if (is_printable(char_q)) begin
                    bus.fb_we      = 1'b1;
                    bus.fb_waddr_x = cur_x;
                    bus.fb_waddr_y = cur_y;
                    bus.fb_wdata   = char_q;
                    if (cur_x != LAST_COL) begin
                        cur_x_n = cur_x + 1'b1;
                    end else begin
                        cur_x_n   = '0;
                        line_feed = 1'b1;
                    end
                end else begin
                    case (char_q)
                        CR: cur_x_n = '0;
                        LF: begin
                            cur_x_n   = '0;
                            line_feed = 1'b1;
                        end
                        BS: if (cur_x != '0) begin
                            cur_x_n        = cur_x - 1'b1;
                            bus.fb_we      = 1'b1;
                            bus.fb_waddr_x = cur_x - 1'b1;
                            bus.fb_waddr_y = cur_y;
                            bus.fb_wdata   = SPACE;
                        end
                        FF: begin
                            w_load  = 1'b1;
                            state_n = CLEAR;
                        end
                        default: ;
                    endcase
                end
                // On the bottom row a new line scrolls instead of moving the cursor down.
                if (line_feed) begin
                    if (cur_y != LAST_ROW) begin
                        cur_y_n = cur_y + 1'b1;
                    end else begin
                        w_load  = 1'b1;
                        state_n = SCROLL_RD;
                    end
                end
            end

            CLEAR: begin
                bus.busy       = 1'b1;
                bus.fb_we      = 1'b1;
                bus.fb_waddr_x = w_x;
                bus.fb_waddr_y = w_y;
                bus.fb_wdata   = SPACE;
                w_step         = 1'b1;
                if (w_done) begin
                    state_n = IDLE;
                    cur_x_n = '0;
                    cur_y_n = '0;
                end
            end

            SCROLL_RD: begin
                bus.busy       = 1'b1;
                bus.fb_raddr_x = w_x;
                bus.fb_raddr_y = w_y + 1'b1;
                if (!bus.disp_busy) state_n = SCROLL_WR;
            end

            SCROLL_WR: begin
                bus.busy       = 1'b1;
                bus.fb_raddr_x = w_x;
                bus.fb_raddr_y = w_y + 1'b1;
                bus.fb_we      = 1'b1;
                bus.fb_waddr_x = w_x;
                bus.fb_waddr_y = w_y;
                bus.fb_wdata   = bus.fb_rdata;
                if (w_done) begin
                    w_load      = 1'b1;
                    w_start_row = LAST_ROW;
                    state_n     = SCROLL_BLANK;
                end else begin
                    w_step  = 1'b1;
                    state_n = SCROLL_RD;
                end
            end

            SCROLL_BLANK: begin
                bus.busy       = 1'b1;
                bus.fb_we      = 1'b1;
                bus.fb_waddr_x = w_x;
                bus.fb_waddr_y = w_y;
                bus.fb_wdata   = SPACE;
                w_step         = 1'b1;
                if (w_done) state_n = IDLE;
            end

            default: state_n = CLEAR;
        endcase
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomised bench for text_console_ctrl: a framebuffer model with display-port contention and a
// screen-level reference model of the console rules.
module tb_text_console_ctrl;
    import console_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_console_ctrl_if bus();

    text_console_ctrl dut (
        .clk_pixel (clk),
        .rst       (rst),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Framebuffer model: one write port, one read port with one-cycle latency.
    // A cycle owned by the display returns unrelated data to the controller.
    logic [CW-1:0] fb_mem [COLS*ROWS];
    bit            seeded     = 1'b0;
    int            oob_writes = 0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < COLS*ROWS; i++) fb_mem[i] <= 7'($urandom);
            seeded <= 1'b1;
        end
        if (bus.fb_we === 1'b1) begin
            if (int'(bus.fb_waddr_x) < COLS && int'(bus.fb_waddr_y) < ROWS)
                fb_mem[int'(bus.fb_waddr_y)*COLS + int'(bus.fb_waddr_x)] <= bus.fb_wdata;
            else
                oob_writes <= oob_writes + 1;
        end
        if (bus.disp_busy)
            bus.fb_rdata <= 7'($urandom);
        else if (int'(bus.fb_raddr_x) < COLS && int'(bus.fb_raddr_y) < ROWS)
            bus.fb_rdata <= fb_mem[int'(bus.fb_raddr_y)*COLS + int'(bus.fb_raddr_x)];
        else
            bus.fb_rdata <= 7'h7F;
    end

    // Display contention driver; also counts scroll copies whose read cycle was owned by the display.
    bit toggle_en = 1'b0;
    bit mon_en    = 1'b0;
    bit prev_db   = 1'b0;
    int rd_viol   = 0;

    initial begin
        bus.disp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && bus.fb_we === 1'b1 && bus.busy === 1'b1 &&
                bus.fb_waddr_y < LAST_ROW && prev_db)
                rd_viol++;
            bus.disp_busy = toggle_en ? 1'($urandom_range(0, 1)) : 1'b0;
            prev_db       = bus.disp_busy;
        end
    end

    // Screen-level reference model.
    logic [CW-1:0] ref_fb [ROWS][COLS];
    int ref_x = 0;
    int ref_y = 0;

    function automatic bit printable(input logic [CW-1:0] c);
        return int'(c) >= 32 && int'(c) <= 126;
    endfunction

    function automatic logic [CW-1:0] rand_print();
        return 7'(32 + $urandom_range(0, 94));
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) ref_fb[r][c] = SPACE;
        ref_x = 0;
        ref_y = 0;
    endtask

    task automatic model_new_line();
        if (ref_y < ROWS - 1) begin
            ref_y++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) ref_fb[r][c] = ref_fb[r+1][c];
            for (int c = 0; c < COLS; c++) ref_fb[ROWS-1][c] = SPACE;
        end
    endtask

    task automatic model_char(input logic [CW-1:0] c);
        if (printable(c)) begin
            ref_fb[ref_y][ref_x] = c;
            if (ref_x < COLS - 1) ref_x++;
            else begin
                ref_x = 0;
                model_new_line();
            end
        end else if (c == CR) begin
            ref_x = 0;
        end else if (c == LF) begin
            ref_x = 0;
            model_new_line();
        end else if (c == BS) begin
            if (ref_x > 0) begin
                ref_x--;
                ref_fb[ref_y][ref_x] = SPACE;
            end
        end else if (c == FF) begin
            model_clear();
        end
    endtask

    function automatic int fb_diff(output int fx, output int fy,
                                   output logic [CW-1:0] got, output logic [CW-1:0] want);
        int n = 0;
        fx = -1; fy = -1; got = '0; want = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (fb_mem[r*COLS + c] !== ref_fb[r][c]) begin
                    if (n == 0) begin
                        fx = c; fy = r; got = fb_mem[r*COLS + c]; want = ref_fb[r][c];
                    end
                    n++;
                end
        return n;
    endfunction

    // Sends one character; checks the write (or its absence) in the cycle after acceptance.
    task automatic send_char(input logic [CW-1:0] c);
        int            waited;
        bit            exp_we;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic [CW-1:0] ed;
        @(negedge clk);
        bus.char_data  = c;
        bus.char_valid = 1'b1;
        waited = 0;
        while (bus.char_ready !== 1'b1 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.char_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout char=%h ready=%b after %0d cycles, required 1", c, bus.char_ready, waited);
            bus.char_valid = 1'b0;
            return;
        end
        exp_we = printable(c) || (c == BS && ref_x > 0);
        ex = printable(c) ? XW'(ref_x) : XW'(ref_x - 1);
        ey = YW'(ref_y);
        ed = printable(c) ? c : SPACE;
        @(negedge clk);
        bus.char_valid = 1'b0;
        checks++;
        if (bus.fb_we !== exp_we ||
            (exp_we && (bus.fb_waddr_x !== ex || bus.fb_waddr_y !== ey || bus.fb_wdata !== ed))) begin
            errors++;
            $display("FAIL char_write char=%h got we=%b (%0d,%0d)=%h required we=%b (%0d,%0d)=%h",
                     c, bus.fb_we, bus.fb_waddr_x, bus.fb_waddr_y, bus.fb_wdata, exp_we, ex, ey, ed);
        end
        model_char(c);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (bus.char_ready !== 1'b1 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Observes a clear sequence starting at the current negedge: cycles, writes, out-of-order writes.
    task automatic observe_clear(output int n, output int writes, output int bad);
        n = 0; writes = 0; bad = 0;
        while (bus.char_ready !== 1'b1 && n < 4000) begin
            if (bus.fb_we === 1'b1) begin
                if (bus.fb_waddr_x !== XW'(writes % COLS) || bus.fb_waddr_y !== YW'(writes / COLS) ||
                    bus.fb_wdata !== SPACE)
                    bad++;
                writes++;
            end
            n++;
            @(negedge clk);
        end
    endtask

    // Moves the cursor to (tx,ty), ty not above the current row, filling rows with random text.
    task automatic goto_cell(input int tx, input int ty);
        send_char(CR);
        while (ref_y < ty) begin
            repeat ($urandom_range(0, 30)) send_char(rand_print());
            send_char(LF);
        end
        repeat (tx) send_char(rand_print());
    endtask

    task automatic test_reset();
        int n, w, bad, d, fx, fy;
        logic [CW-1:0] g, q;
        bus.char_valid = 1'b0;
        bus.char_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.char_ready !== 1'b0 || bus.cursor_x !== '0 || bus.cursor_y !== '0 ||
            bus.fb_raddr_x !== '0 || bus.fb_raddr_y !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b cursor=(%0d,%0d) raddr=(%0d,%0d) required 0,(0,0),(0,0)",
                     bus.char_ready, bus.cursor_x, bus.cursor_y, bus.fb_raddr_x, bus.fb_raddr_y);
        end
        rst = 1'b0;
        model_clear();
        observe_clear(n, w, bad);
        checks++;
        if (n != 1900 || w != 1900) begin
            errors++;
            $display("FAIL reset_clear_len cycles=%0d writes=%0d required 1900/1900", n, w);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_clear_order bad=%0d required 0", bad);
        end
        checks++;
        if (bus.char_ready !== 1'b1 || bus.cursor_x !== '0 || bus.cursor_y !== '0) begin
            errors++;
            $display("FAIL reset_idle ready=%b cursor=(%0d,%0d) required 1,(0,0)", bus.char_ready, bus.cursor_x, bus.cursor_y);
        end
        d = fb_diff(fx, fy, g, q);
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL reset_fb cells=%0d first (%0d,%0d) got %h required %h", d, fx, fy, g, q);
        end
    endtask

    task automatic test_print_ab();
        int cyc;
        send_char(7'h41);
        send_char(7'h42);
        wait_ready(cyc);
        checks++;
        if (bus.cursor_x !== 6'd2 || bus.cursor_y !== 6'd0 || ref_x != 2 || ref_y != 0) begin
            errors++;
            $display("FAIL ab_cursor got (%0d,%0d) model (%0d,%0d) required (2,0)", bus.cursor_x, bus.cursor_y, ref_x, ref_y);
        end
    endtask

    task automatic test_controls();
        int cyc, d, fx, fy;
        logic [CW-1:0] g, q;
        logic [CW-1:0] ignored [4];
        ignored[0] = 7'h01; ignored[1] = 7'h1B; ignored[2] = 7'h7F; ignored[3] = 7'h00;
        for (int i = 0; i < 6; i++) begin
            send_char(ignored[$urandom_range(0, 3)]);
            send_char(rand_print());
        end
        send_char(CR);
        wait_ready(cyc);
        checks++;
        if (bus.cursor_x !== XW'(ref_x) || bus.cursor_y !== YW'(ref_y) || ref_x != 0) begin
            errors++;
            $display("FAIL ctrl_cursor got (%0d,%0d) required (%0d,%0d)", bus.cursor_x, bus.cursor_y, ref_x, ref_y);
        end
        d = fb_diff(fx, fy, g, q);
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL ctrl_fb cells=%0d first (%0d,%0d) got %h required %h", d, fx, fy, g, q);
        end
    endtask

    task automatic test_line_wrap();
        int cyc, d, fx, fy;
        logic [CW-1:0] g, q;
        goto_cell(49, 5);
        send_char(7'h41);
        wait_ready(cyc);
        checks++;
        if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 6'd6 || fb_mem[5*COLS + 49] !== 7'h41) begin
            errors++;
            $display("FAIL wrap_cursor got (%0d,%0d) cell=%h required (0,6) cell=41",
                     bus.cursor_x, bus.cursor_y, fb_mem[5*COLS + 49]);
        end
        send_char(BS);
        wait_ready(cyc);
        checks++;
        if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 6'd6) begin
            errors++;
            $display("FAIL bs_at_col0 cursor=(%0d,%0d) required (0,6)", bus.cursor_x, bus.cursor_y);
        end
        send_char(rand_print());
        send_char(rand_print());
        send_char(BS);
        wait_ready(cyc);
        checks++;
        if (bus.cursor_x !== 6'd1 || fb_mem[6*COLS + 1] !== SPACE) begin
            errors++;
            $display("FAIL bs_erase cursor_x=%0d cell=%h required 1 and 20", bus.cursor_x, fb_mem[6*COLS + 1]);
        end
        d = fb_diff(fx, fy, g, q);
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL wrap_fb cells=%0d first (%0d,%0d) got %h required %h", d, fx, fy, g, q);
        end
    endtask

    task automatic test_scroll(input bit contend, input bit via_wrap);
        int cyc, d, fx, fy;
        logic [CW-1:0] g, q;
        if (ref_y < ROWS - 1) goto_cell(10, ROWS - 1);
        else begin
            send_char(CR);
            repeat (via_wrap ? COLS - 1 : $urandom_range(1, 40)) send_char(rand_print());
        end
        rd_viol   = 0;
        toggle_en = contend;
        mon_en    = 1'b1;
        send_char(via_wrap ? rand_print() : LF);
        wait_ready(cyc);
        toggle_en = 1'b0;
        mon_en    = 1'b0;
        checks++;
        if (bus.char_ready !== 1'b1) begin
            errors++;
            $display("FAIL scroll_timeout contend=%0d ready=%b after %0d cycles", contend, bus.char_ready, cyc);
        end
        d = fb_diff(fx, fy, g, q);
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL scroll_fb contend=%0d cells=%0d first (%0d,%0d) got %h required %h", contend, d, fx, fy, g, q);
        end
        checks++;
        if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 6'd37) begin
            errors++;
            $display("FAIL scroll_cursor got (%0d,%0d) required (0,37)", bus.cursor_x, bus.cursor_y);
        end
        checks++;
        if (rd_viol != 0) begin
            errors++;
            $display("FAIL scroll_read_while_busy count=%0d required 0", rd_viol);
        end
    endtask

    task automatic test_reset_mid_scroll();
        int n, w, bad, d, fx, fy;
        logic [CW-1:0] g, q;
        send_char(LF);
        repeat ($urandom_range(200, 1500)) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midscroll_busy busy=%b required 1", bus.busy);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        observe_clear(n, w, bad);
        checks++;
        if (n != 1900 || w != 1900 || bad != 0) begin
            errors++;
            $display("FAIL midscroll_clear cycles=%0d writes=%0d bad=%0d required 1900/1900/0", n, w, bad);
        end
        d = fb_diff(fx, fy, g, q);
        checks++;
        if (d != 0 || bus.cursor_x !== '0 || bus.cursor_y !== '0) begin
            errors++;
            $display("FAIL midscroll_after cells=%0d cursor=(%0d,%0d) required 0,(0,0)", d, bus.cursor_x, bus.cursor_y);
        end
    endtask

    task automatic test_form_feed();
        int n, w, bad, d, fx, fy;
        logic [CW-1:0] g, q;
        repeat (5) send_char(LF);
        repeat ($urandom_range(3, 20)) send_char(rand_print());
        send_char(FF);
        @(negedge clk);
        observe_clear(n, w, bad);
        checks++;
        if (n != 1900 || w != 1900 || bad != 0) begin
            errors++;
            $display("FAIL ff_clear cycles=%0d writes=%0d bad=%0d required 1900/1900/0", n, w, bad);
        end
        d = fb_diff(fx, fy, g, q);
        checks++;
        if (d != 0 || bus.char_ready !== 1'b1 || bus.cursor_x !== '0 || bus.cursor_y !== '0) begin
            errors++;
            $display("FAIL ff_after cells=%0d ready=%b cursor=(%0d,%0d) required 0,1,(0,0)",
                     d, bus.char_ready, bus.cursor_x, bus.cursor_y);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_print_ab();
        test_controls();
        test_line_wrap();
        test_scroll(1'b0, 1'b0);
        test_scroll(1'b1, 1'b0);
        test_scroll(1'b1, 1'b1);
        test_reset_mid_scroll();
        test_form_feed();
        checks++;
        if (oob_writes != 0) begin
            errors++;
            $display("FAIL write_range out_of_range_writes=%0d required 0", oob_writes);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
